debug_unit_ctrl: RTL and testbench
==================================

Name: debug_unit_ctrl

Overview:
- Host-side debug controller that sits directly upstream of PIPELINE and drives all of its i_du_* inputs.
- Receives a byte command stream from a UART receiver and writes program words into instruction memory.
- Runs the pipeline continuously to HALT, or steps it one clock at a time.
- After a run or step, streams the register file and the first data-memory words back through a UART transmitter.

Parameters:
- NB_DATA, 32, width of data words and addresses.
- IMEM_WORDS, 64, instruction-memory capacity in words; load limit.
- DUMP_MEM_WORDS, 16, number of data-memory words sent after the 32 registers in a dump.
- HALT_WORD, 32'hFC000000, instruction word that terminates a load.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-low (asserted when 0)
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe: i_rx_data is valid
- o_tx_data  out  8  byte to transmit
- o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data
- i_tx_done  in  1  one-cycle strobe: transmitter finished current byte
- o_du_data  out  32  instruction word to write
- o_du_inst_addr_wr  out  32  instruction-memory byte address
- o_du_write_en  out  1  instruction-memory write enable
- o_du_read_en  out  1  pipeline run enable; pipeline advances only while 1
- o_du_reg_addr  out  32  register index for readback (0..31)
- o_du_mem_addr  out  32  data-memory byte address for readback
- i_du_halt  in  1  pipeline has retired HALT
- i_du_regs_mem_data  in  32  combinational register readback
- i_du_mem_data  in  32  combinational data-memory readback
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (i_reset==0, async): state IDLE; all outputs 0; byte counter, word buffer and load address cleared; any partial word discarded. Reset mid-load or mid-dump aborts without further TX.
- Commands are accepted only in IDLE, on i_rx_valid.
  - 'L' (0x4C): load.
  - 'R' (0x52): run.
  - 'S' (0x53): step.
  - Any other byte is dropped; state stays IDLE.
  - Bytes arriving while not IDLE (except load payload) are dropped.
- LOAD_BYTE: collect 4 bytes MSB first into the word buffer.
- LOAD_WRITE: on the 4th byte, present the word for exactly 1 cycle.
  - o_du_data = word, o_du_inst_addr_wr = load_addr, o_du_write_en = 1.
  - Then load_addr += 4.
  - If word == HALT_WORD: TX 0x06 (ack), go IDLE.
  - Else if load_addr has reached IMEM_WORDS*4: TX 0xEE (overflow), go IDLE.
  - Else return to LOAD_BYTE.
  - load_addr restarts at 0 on each 'L'.
- RUN: o_du_read_en = 1 from the cycle after the command until the first cycle i_du_halt == 1. o_du_read_en drops to 0 in that same cycle (registered, so one cycle late is not permitted: compute from i_du_halt combinationally into the next state, with read_en a Moore output of RUN gated by !i_du_halt). Then DUMP.
- STEP: o_du_read_en = 1 for exactly 1 cycle, then DUMP. If i_du_halt is already 1, read_en stays 0 and DUMP follows immediately. The same applies to RUN.
- DUMP: 32 registers, then DUMP_MEM_WORDS memory words (index k → o_du_mem_addr = 4k).
  - Each item goes through D_SETUP → D_CAPTURE → 4× (D_SEND, D_WAIT).
  - D_SETUP drives the address for 1 cycle; D_CAPTURE latches the 32-bit readback.
  - D_SEND pulses o_tx_start with the byte (MSB first); D_WAIT waits for i_tx_done.
  - Total bytes = 4*(32+DUMP_MEM_WORDS) = 192 at defaults. Then IDLE.
- TX rule: at most one o_tx_start outstanding. No new start until i_tx_done has been seen. i_tx_done outside a wait state is ignored.
- Address outputs hold their last value between uses. o_du_write_en and o_tx_start are never high for more than 1 cycle.

Decomposition:
- Shared package debug_pkg:
  - state encoding (IDLE, LOAD_BYTE, LOAD_WRITE, RUN, STEP, D_SETUP, D_CAPTURE, D_SEND, D_WAIT);
  - command byte constants CMD_LOAD/CMD_RUN/CMD_STEP;
  - ACK_BYTE 0x06, ERR_BYTE 0xEE;
  - HALT_WORD default.
- One natural sub-module: du_word_serializer. It takes a 32-bit word plus a start strobe, emits 4 MSB-first bytes over the tx handshake, and returns a done strobe. It owns D_SEND/D_WAIT.

Test Plan:
- Load: 'L', then 24 43 00 01, AC 03 00 04, FC 00 00 00 → three write_en pulses at addresses 0, 4, 8 with those words; TX 0x06; o_busy back to 0.
- Overflow: IMEM_WORDS=2, 'L' plus 2 non-HALT words → writes at 0 and 4, then TX 0xEE, IDLE; a further byte 0x11 causes no write.
- Run: after the load above, 'R' → read_en high until i_du_halt, then 192 TX bytes. Register 3 bytes = value of $v1. Memory word 1 (bytes 4..7 of the memory section) equals the same value stored by the SW.
- Step: 'S' with halt low → read_en high exactly 1 cycle, then a full 192-byte dump. 'S' with halt high → read_en never asserted, dump still sent.
- Handshake: i_tx_done delayed by 10 cycles → exactly one o_tx_start per done; a spurious i_tx_done in IDLE is ignored; an unknown command 0x7A produces no TX.
- Reset: i_reset driven low after 2 payload bytes of a load, then released → all outputs 0. A fresh 'L' with 4 bytes writes address 0 with only the new bytes.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants for the host-side debug controller: FSM state codes,
// command/response bytes and the default HALT instruction word.
package debug_pkg;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_LOAD_BYTE  = 4'd1;
    localparam logic [3:0] ST_LOAD_WRITE = 4'd2;
    localparam logic [3:0] ST_RUN        = 4'd3;
    localparam logic [3:0] ST_STEP       = 4'd4;
    localparam logic [3:0] ST_D_SETUP    = 4'd5;
    localparam logic [3:0] ST_D_CAPTURE  = 4'd6;
    localparam logic [3:0] ST_D_SEND     = 4'd7;
    localparam logic [3:0] ST_D_WAIT     = 4'd8;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

    // Shift a received byte into the low end of a word (MSB-first assembly).
    function automatic logic [31:0] push_byte(input logic [31:0] word, input logic [7:0] b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/du_word_serializer.sv
// Sends one 32-bit word as 4 MSB-first bytes over a start/done transmitter
// handshake; only one byte is ever outstanding. Pulses o_done after the
// 4th byte has been acknowledged.
module du_word_serializer
    import debug_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_word,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    output logic        o_done
);

    logic [3:0]  state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        done_q, done_d;

    // Next-state: latch the word on start, then alternate send/wait per byte.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    word_d  = i_word;
                    cnt_d   = 2'd0;
                    state_d = ST_D_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_D_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = word_q[31:24];
                word_d     = {word_q[23:0], 8'h00};
                state_d    = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                if (i_tx_done) begin
                    if (cnt_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ST_D_SEND;
                    end
                end else begin
                    state_d = ST_D_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            word_q     <= 32'd0;
            cnt_q      <= 2'd0;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_done     = done_q;

endmodule

// File: rtl/debug_unit_ctrl.sv
// Host-side debug controller: decodes UART commands, loads instruction
// memory, runs or single-steps the pipeline and dumps registers plus the
// first data-memory words back over the UART transmitter.
module debug_unit_ctrl
    import debug_pkg::*;
#(
    parameter int                  NB_DATA        = 32,
    parameter int                  IMEM_WORDS     = 64,
    parameter int                  DUMP_MEM_WORDS = 16,
    parameter logic [NB_DATA-1:0]  HALT_WORD      = HALT_WORD_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_du_data,
    output logic [NB_DATA-1:0] o_du_inst_addr_wr,
    output logic               o_du_write_en,
    output logic               o_du_read_en,
    output logic [NB_DATA-1:0] o_du_reg_addr,
    output logic [NB_DATA-1:0] o_du_mem_addr,
    input  logic               i_du_halt,
    input  logic [NB_DATA-1:0] i_du_regs_mem_data,
    input  logic [NB_DATA-1:0] i_du_mem_data,
    output logic               o_busy
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
    localparam logic [7:0]  LAST_ITEM  = 8'(32 + DUMP_MEM_WORDS - 1);

    logic [3:0]  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] load_addr_q, load_addr_d;
    logic [7:0]  item_q, item_d;
    logic [31:0] du_data_q, du_data_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        write_en_q, write_en_d;
    logic [31:0] reg_addr_q, reg_addr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        ser_start_s;
    logic [31:0] ser_word_s;
    logic [7:0]  ser_tx_data_s;
    logic        ser_tx_start_s;
    logic        ser_done_s;

    // Items 0..31 are registers; the rest come from data memory.
    assign ser_word_s = (item_q < 8'd32) ? i_du_regs_mem_data : i_du_mem_data;

    // Command decode, load sequencing, run/step control and dump item walk.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        load_addr_d = load_addr_q;
        item_d      = item_q;
        du_data_d   = du_data_q;
        inst_addr_d = inst_addr_q;
        write_en_d  = 1'b0;
        reg_addr_d  = reg_addr_q;
        mem_addr_d  = mem_addr_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        ser_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        byte_cnt_d  = 2'd0;
                        word_d      = 32'd0;
                        load_addr_d = 32'd0;
                        state_d     = ST_LOAD_BYTE;
                    end else if (i_rx_data == CMD_RUN) begin
                        state_d = ST_RUN;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_d = ST_STEP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_BYTE: begin
                if (i_rx_valid) begin
                    word_d     = push_byte(word_q, i_rx_data);
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        du_data_d   = push_byte(word_q, i_rx_data);
                        inst_addr_d = load_addr_q;
                        write_en_d  = 1'b1;
                        state_d     = ST_LOAD_WRITE;
                    end else begin
                        state_d = ST_LOAD_BYTE;
                    end
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_LOAD_WRITE: begin
                load_addr_d = load_addr_q + 32'd4;
                if (du_data_q == HALT_WORD) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                    state_d    = ST_IDLE;
                end else if (load_addr_q + 32'd4 >= IMEM_BYTES) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ERR_BYTE;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_RUN: begin
                if (i_du_halt) begin
                    item_d  = 8'd0;
                    state_d = ST_D_SETUP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                item_d  = 8'd0;
                state_d = ST_D_SETUP;
            end
            ST_D_SETUP: begin
                if (item_q < 8'd32) begin
                    reg_addr_d = {24'd0, item_q};
                end else begin
                    mem_addr_d = {22'd0, item_q - 8'd32, 2'b00};
                end
                state_d = ST_D_CAPTURE;
            end
            ST_D_CAPTURE: begin
                ser_start_s = 1'b1;
                state_d     = ST_D_SEND;
            end
            ST_D_SEND: begin
                if (ser_done_s) begin
                    if (item_q == LAST_ITEM) begin
                        state_d = ST_IDLE;
                    end else begin
                        item_d  = item_q + 8'd1;
                        state_d = ST_D_SETUP;
                    end
                end else begin
                    state_d = ST_D_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, load bookkeeping and registered pipeline/UART outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            word_q      <= 32'd0;
            load_addr_q <= 32'd0;
            item_q      <= 8'd0;
            du_data_q   <= 32'd0;
            inst_addr_q <= 32'd0;
            write_en_q  <= 1'b0;
            reg_addr_q  <= 32'd0;
            mem_addr_q  <= 32'd0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            load_addr_q <= load_addr_d;
            item_q      <= item_d;
            du_data_q   <= du_data_d;
            inst_addr_q <= inst_addr_d;
            write_en_q  <= write_en_d;
            reg_addr_q  <= reg_addr_d;
            mem_addr_q  <= mem_addr_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    du_word_serializer u_ser (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (ser_start_s),
        .i_word     (ser_word_s),
        .i_tx_done  (i_tx_done),
        .o_tx_data  (ser_tx_data_s),
        .o_tx_start (ser_tx_start_s),
        .o_done     (ser_done_s)
    );

    // Ack/error bytes and dump bytes never overlap, so a plain merge suffices.
    assign o_tx_start = tx_start_q | ser_tx_start_s;
    assign o_tx_data  = ser_tx_start_s ? ser_tx_data_s : tx_data_q;

    // Run enable drops in the very cycle halt is seen.
    assign o_du_read_en      = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_du_halt;
    assign o_du_data         = du_data_q;
    assign o_du_inst_addr_wr = inst_addr_q;
    assign o_du_write_en     = write_en_q;
    assign o_du_reg_addr     = reg_addr_q;
    assign o_du_mem_addr     = mem_addr_q;
    assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Randomized self-checking bench for debug_unit_ctrl with a behavioural
// model of loads and dumps, a simple transmitter and a halt-after-N pipeline.
module tb_debug_unit_ctrl;

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam int          IMEM = 64;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic [31:0] o_du_data;
    logic [31:0] o_du_inst_addr_wr;
    logic        o_du_write_en;
    logic        o_du_read_en;
    logic [31:0] o_du_reg_addr;
    logic [31:0] o_du_mem_addr;
    logic        i_du_halt;
    logic [31:0] i_du_regs_mem_data;
    logic [31:0] i_du_mem_data;
    logic        o_busy;

    logic [31:0] regs [32];
    logic [31:0] mem  [16];

    logic        tx_done_m, spur_done, halt_force, halt_run;
    int          tx_cnt, tx_delay, read_cnt, run_base, halt_budget;
    int          overlap_cnt, pulse_viol;
    logic        prev_we, prev_ts;
    int          pass_cnt, chk_cnt;

    logic [7:0]  tx_q[$];
    logic [7:0]  exp_tx[$];
    logic [63:0] wr_q[$];
    logic [63:0] exp_wr[$];
    logic [7:0]  payload[$];

    debug_unit_ctrl dut (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_rx_data          (i_rx_data),
        .i_rx_valid         (i_rx_valid),
        .o_tx_data          (o_tx_data),
        .o_tx_start         (o_tx_start),
        .i_tx_done          (i_tx_done),
        .o_du_data          (o_du_data),
        .o_du_inst_addr_wr  (o_du_inst_addr_wr),
        .o_du_write_en      (o_du_write_en),
        .o_du_read_en       (o_du_read_en),
        .o_du_reg_addr      (o_du_reg_addr),
        .o_du_mem_addr      (o_du_mem_addr),
        .i_du_halt          (i_du_halt),
        .i_du_regs_mem_data (i_du_regs_mem_data),
        .i_du_mem_data      (i_du_mem_data),
        .o_busy             (o_busy)
    );

    assign i_tx_done = tx_done_m | spur_done;
    assign i_du_halt = halt_force | halt_run;
    assign i_du_regs_mem_data = (o_du_reg_addr < 32'd32) ? regs[o_du_reg_addr[4:0]] : 32'hDEAD_BEEF;
    assign i_du_mem_data      = (o_du_mem_addr < 32'd64) ? mem[o_du_mem_addr[5:2]] : 32'hBAD0_BAD0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Monitor: records writes and TX bytes, emulates transmitter and pipeline halt.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_du_write_en) wr_q.push_back({o_du_inst_addr_wr, o_du_data});
            if (o_du_write_en && prev_we) pulse_viol++;
            if (o_tx_start && prev_ts) pulse_viol++;
            prev_we = o_du_write_en;
            prev_ts = o_tx_start;
            if (o_du_read_en) read_cnt++;
            halt_run = (halt_budget != 0) && ((read_cnt - run_base) >= halt_budget);
            tx_done_m = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) tx_done_m = 1'b1;
            end
            if (o_tx_start) begin
                if (tx_cnt != 0) overlap_cnt++;
                tx_q.push_back(o_tx_data);
                tx_cnt = tx_delay;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((o_busy || tx_cnt != 0) && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
        check_eq(tag, {31'd0, o_busy}, 32'd0);
    endtask

    // Reference: split payload into words, write each at 4*index, stop on HALT or full memory.
    task automatic model_load();
        logic [31:0] w;
        for (int k = 0; k < payload.size() / 4; k++) begin
            w = {payload[4*k], payload[4*k+1], payload[4*k+2], payload[4*k+3]};
            exp_wr.push_back({32'(4 * k), w});
            if (w == HALT) begin
                exp_tx.push_back(8'h06);
                break;
            end
            if (k + 1 == IMEM) begin
                exp_tx.push_back(8'hEE);
                break;
            end
        end
    endtask

    // Reference: all 32 registers then 16 memory words, each MSB first.
    task automatic model_dump();
        logic [31:0] w;
        for (int k = 0; k < 48; k++) begin
            w = (k < 32) ? regs[k] : mem[k-32];
            for (int b = 3; b >= 0; b--) exp_tx.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic clear_queues();
        tx_q.delete(); exp_tx.delete(); wr_q.delete(); exp_wr.delete();
    endtask

    task automatic compare_queues(input string tag);
        check_eq({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++) begin
            check_eq($sformatf("%s_waddr%0d", tag, k), wr_q[k][63:32], exp_wr[k][63:32]);
            check_eq($sformatf("%s_wdata%0d", tag, k), wr_q[k][31:0], exp_wr[k][31:0]);
        end
        check_eq({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int k = 0; k < tx_q.size() && k < exp_tx.size(); k++)
            check_eq($sformatf("%s_tx%0d", tag, k), {24'd0, tx_q[k]}, {24'd0, exp_tx[k]});
        clear_queues();
    endtask

    task automatic do_load(input string tag);
        clear_queues();
        model_load();
        send_byte(8'h4C);
        foreach (payload[k]) send_byte(payload[k]);
        wait_idle({tag, "_idle"}, 5000);
        compare_queues(tag);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) payload.push_back(w[8*b +: 8]);
    endtask

    task automatic do_dump(input string tag, input logic [7:0] cmd, input int budget,
                           input logic force_halt, input int exp_reads);
        int base;
        halt_force  = force_halt;
        halt_budget = budget;
        run_base    = read_cnt;
        repeat (2) @(negedge i_clk);
        clear_queues();
        model_dump();
        base = read_cnt;
        send_byte(cmd);
        wait_idle({tag, "_idle"}, 20000);
        check_eq({tag, "_reads"}, 32'(read_cnt - base), 32'(exp_reads));
    endtask

    initial begin
        logic [31:0] v1, w;
        int          n;
        pass_cnt = 0; chk_cnt = 0;
        i_reset = 1'b0; i_rx_data = 8'd0; i_rx_valid = 1'b0;
        tx_done_m = 1'b0; spur_done = 1'b0; halt_force = 1'b0; halt_run = 1'b0;
        tx_cnt = 0; tx_delay = 3; read_cnt = 0; run_base = 0; halt_budget = 0;
        overlap_cnt = 0; pulse_viol = 0; prev_we = 1'b0; prev_ts = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;

        // Reset state
        repeat (3) @(negedge i_clk);
        check_eq("rst_flags", {27'd0, o_busy, o_du_write_en, o_du_read_en, o_tx_start, 1'b0}, 32'd0);
        check_eq("rst_txdata", {24'd0, o_tx_data}, 32'd0);
        check_eq("rst_dudata", o_du_data, 32'd0);
        check_eq("rst_iaddr", o_du_inst_addr_wr, 32'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);

        // Directed load from the test plan
        payload = '{8'h24, 8'h43, 8'h00, 8'h01, 8'hAC, 8'h03, 8'h00, 8'h04,
                    8'hFC, 8'h00, 8'h00, 8'h00};
        do_load("load_tp");

        // Run after that load: $v1 in reg 3, same value stored at memory word 1
        v1 = $urandom;
        regs[3] = v1;
        mem[1]  = v1;
        tx_delay = $urandom_range(1, 10);
        n = $urandom_range(3, 20);
        do_dump("run", 8'h52, n, 1'b0, n);
        check_eq("run_reg3", {tx_q[12], tx_q[13], tx_q[14], tx_q[15]}, v1);
        check_eq("run_mem1", {tx_q[132], tx_q[133], tx_q[134], tx_q[135]}, v1);
        compare_queues("run");

        // Randomized loads ending in HALT
        for (int t = 0; t < 3; t++) begin
            payload.delete();
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                if (w == HALT) w = w ^ 32'd1;
                push_word(w);
            end
            push_word(HALT);
            do_load($sformatf("rload%0d", t));
        end

        // Overflow: fill memory without HALT, then a stray byte must not write
        payload.delete();
        for (int k = 0; k < IMEM; k++) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'd1;
            push_word(w);
        end
        do_load("ovf");
        send_byte(8'h11);
        repeat (4) @(negedge i_clk);
        check_eq("ovf_stray_wr", 32'(wr_q.size()), 32'd0);
        check_eq("ovf_stray_busy", {31'd0, o_busy}, 32'd0);

        // Step with halt low, step with halt high, run with halt already high
        tx_delay = $urandom_range(1, 10);
        do_dump("step_lo", 8'h53, 0, 1'b0, 1);
        compare_queues("step_lo");
        do_dump("step_hi", 8'h53, 0, 1'b1, 0);
        compare_queues("step_hi");
        do_dump("run_hi", 8'h52, 0, 1'b1, 0);
        compare_queues("run_hi");

        // Slow transmitter: one start per done
        tx_delay = 10;
        n = $urandom_range(1, 8);
        do_dump("run_slow", 8'h52, n, 1'b0, n);
        compare_queues("run_slow");
        halt_force = 1'b0;
        halt_budget = 0;

        // Spurious done in IDLE and unknown command
        @(negedge i_clk);
        spur_done = 1'b1;
        @(negedge i_clk);
        spur_done = 1'b0;
        send_byte(8'h7A);
        repeat (6) @(negedge i_clk);
        check_eq("idle_noise_tx", 32'(tx_q.size()), 32'd0);
        check_eq("idle_noise_busy", {31'd0, o_busy}, 32'd0);
        check_eq("idle_noise_wr", 32'(wr_q.size()), 32'd0);

        // Reset in the middle of a load payload
        clear_queues();
        send_byte(8'h4C);
        send_byte(8'hA5);
        send_byte(8'h5A);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clk);
        check_eq("mrst_flags", {27'd0, o_busy, o_du_write_en, o_du_read_en, o_tx_start, 1'b0}, 32'd0);
        check_eq("mrst_regaddr", o_du_reg_addr, 32'd0);
        check_eq("mrst_memaddr", o_du_mem_addr, 32'd0);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        payload.delete();
        w = $urandom;
        if (w == HALT) w = w ^ 32'd1;
        push_word(w);
        push_word(HALT);
        do_load("mrst_load");

        check_eq("tx_overlap", 32'(overlap_cnt), 32'd0);
        check_eq("pulse_width", 32'(pulse_viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
